lfsr_range_gen: RTL and testbench

Parametrised Fibonacci LFSR pseudo-random source with a request/valid port that returns a uniformly distributed value in `[0, limit)`, using masked rejection sampling with a bounded retry count. It supersedes the fixed 8-bit free-running generator for game logic: spawn positions, dice, shuffles. Default parameters reproduce the existing 8-bit sequence bit-exactly.

---
 rtl/lfsr_range_gen.sv | 146 ++++++++++++++
 tb/tb_lfsr_range_gen.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_range_gen.sv
// lfsr_range_gen: Fibonacci LFSR with a request/valid port returning a uniform
// value in [0, limit) by masked rejection sampling with bounded retries.
// Optional feature macro: LFSR_LOCKUP_GUARD_EN (all-zero state recovers to SEED).
`timescale 1ns/1ps
module lfsr_range_gen #(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] TAPS      = 8'h8D,
    parameter logic [WIDTH-1:0] SEED      = 8'h0F,
    parameter int unsigned      OUT_W     = 8,
    parameter int unsigned      MAX_TRIES = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             req,
    input  logic [OUT_W-1:0] limit,
    output logic             busy,
    output logic             valid,
    output logic [OUT_W-1:0] value,
    output logic [WIDTH-1:0] raw
);

    localparam int unsigned      TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

    typedef enum logic {
        IDLE,
        DRAW
    } fsm_t;

    fsm_t             fsm_q,   fsm_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic [OUT_W-1:0] lim_q,   lim_d;
    logic [OUT_W-1:0] mask_q,  mask_d;
    logic [TRY_W-1:0] tries_q, tries_d;
    logic             busy_q,  busy_d;
    logic             valid_q, valid_d;
    logic [OUT_W-1:0] value_q, value_d;

    logic             feedback;
    logic [WIDTH-1:0] lfsr_next;
    logic [WIDTH-1:0] load_val;
    logic [OUT_W-1:0] lim_m1;
    logic [OUT_W-1:0] cand;
    logic             advance;

    // Candidate next LFSR state and the value a seed load would install
    always_comb begin
        feedback = ^(state_q & TAPS);
`ifdef LFSR_LOCKUP_GUARD_EN
        lfsr_next = (state_q == '0) ? SEED : {state_q[WIDTH-2:0], feedback};
        load_val  = (seed_in == '0) ? SEED : seed_in;
`else
        lfsr_next = {state_q[WIDTH-2:0], feedback};
        load_val  = seed_in;
`endif
    end

    // Draw FSM: latch range on request, test one candidate per DRAW cycle
    always_comb begin
        fsm_d   = fsm_q;
        lim_d   = lim_q;
        mask_d  = mask_q;
        tries_d = tries_q;
        busy_d  = busy_q;
        valid_d = 1'b0;
        value_d = value_q;
        advance = 1'b0;
        lim_m1  = limit - OUT_W'(1);
        cand    = state_q[OUT_W-1:0] & mask_q;

        case (fsm_q)
            IDLE: begin
                advance = enable;
                if (req) begin
                    lim_d   = limit;
                    // Smear the highest set bit of limit-1 downward: limit=0
                    // wraps to all ones, limit=1 gives an empty mask.
                    for (int unsigned i = 0; i < OUT_W; i++) begin
                        mask_d[i] = |(lim_m1 >> i);
                    end
                    tries_d = '0;
                    busy_d  = 1'b1;
                    fsm_d   = DRAW;
                end
            end
            DRAW: begin
                advance = 1'b1;
                if (lim_q == '0 || cand < lim_q) begin
                    value_d = cand;
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    fsm_d   = IDLE;
                end else if (tries_q == LAST_TRY) begin
                    // mask < 2*lim_q, so one subtraction lands inside the range
                    value_d = cand - lim_q;
                    valid_d = 1'b1;
                    busy_d  = 1'b0;
                    fsm_d   = IDLE;
                end else begin
                    tries_d = tries_q + 1'b1;
                end
            end
            default: fsm_d = IDLE;
        endcase

        if (seed_load) begin
            state_d = load_val;
        end else if (advance) begin
            state_d = lfsr_next;
        end else begin
            state_d = state_q;
        end
    end

    // Register all state and outputs; synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            fsm_q   <= IDLE;
            state_q <= SEED;
            lim_q   <= '0;
            mask_q  <= '0;
            tries_q <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            value_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            lim_q   <= lim_d;
            mask_q  <= mask_d;
            tries_q <= tries_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            value_q <= value_d;
        end
    end

    assign busy  = busy_q;
    assign valid = valid_q;
    assign value = value_q;
    assign raw   = state_q;

endmodule

// File: tb/tb_lfsr_range_gen.sv
// tb_lfsr_range_gen: scoreboard bench for lfsr_range_gen with a behavioural model.
`timescale 1ns/1ps
module tb_lfsr_range_gen;

    localparam int W         = 8;
    localparam int OW        = 8;
    localparam int TAPS      = 'h8D;
    localparam int SEED      = 'h0F;
    localparam int MAX_TRIES = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          enable = 1'b0;
    logic          seed_load = 1'b0;
    logic [W-1:0]  seed_in = '0;
    logic          req = 1'b0;
    logic [OW-1:0] limit = '0;
    logic          busy;
    logic          valid;
    logic [OW-1:0] value;
    logic [W-1:0]  raw;

    lfsr_range_gen #(
        .WIDTH     (W),
        .TAPS      (8'h8D),
        .SEED      (8'h0F),
        .OUT_W     (OW),
        .MAX_TRIES (MAX_TRIES)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .seed_load (seed_load),
        .seed_in   (seed_in),
        .req       (req),
        .limit     (limit),
        .busy      (busy),
        .valid     (valid),
        .value     (value),
        .raw       (raw)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int val;
        int cyc;
    } exp_t;
    exp_t exp_q[$];

    int tests = 0;
    int fails = 0;
    int m_state = SEED;
    int m_busy  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Next LFSR value from the arithmetic definition: shift left, append tap parity
    function automatic int nxt(input int s);
        int p;
        p = 0;
`ifdef LFSR_LOCKUP_GUARD_EN
        if (s == 0) return SEED;
`endif
        for (int i = 0; i < W; i++)
            if ((((TAPS >> i) & 1) == 1) && (((s >> i) & 1) == 1)) p++;
        return ((s * 2) % 256) + (p % 2);
    endfunction

    function automatic int load(input int s);
`ifdef LFSR_LOCKUP_GUARD_EN
        if (s == 0) return SEED;
`endif
        return s;
    endfunction

    // Drive one edge's inputs, update the model for that edge, then check raw/busy
    task automatic cycle(input logic rst_n, input logic en, input logic sl,
                         input int sin, input logic rq, input int lim);
        int lim_e, mask, s, c, n, val;
        bit done;
        reset = rst_n; enable = en; seed_load = sl;
        seed_in = W'(sin); req = rq; limit = OW'(lim);
        if (!rst_n) begin
            m_state = SEED;
            m_busy  = 0;
            while (exp_q.size() > 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
        end else if (m_busy > 0) begin
            m_state = sl ? load(sin) : nxt(m_state);
            m_busy--;
        end else begin
            if (sl) m_state = load(sin);
            else if (en) m_state = nxt(m_state);
            if (rq) begin
                lim_e = (lim == 0) ? 256 : lim;
                mask = 0;
                while (mask < lim_e - 1) mask = mask * 2 + 1;
                s = m_state; n = 0; val = 0; done = 0;
                for (int k = 0; k < MAX_TRIES && !done; k++) begin
                    c = s % (mask + 1);
                    n = k + 1;
                    if (c < lim_e) begin
                        val = c; done = 1;
                    end else if (k == MAX_TRIES - 1) begin
                        val = (c - lim_e + 256) % 256; done = 1;
                    end
                    s = nxt(s);
                end
                exp_q.push_back('{val: val, cyc: cyc + 1 + n});
                m_busy = n;
            end
        end
        @(posedge clock);
        #1;
        chk("raw_model", raw, m_state);
        chk("busy_model", busy, (m_busy > 0) ? 1 : 0);
    endtask

    // Monitor: every valid strobe must match the oldest outstanding draw
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_valid: got valid=1 value=0x%0h, expected no strobe (cycle %0d)", value, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("draw_value", value, e.val);
                    chk("draw_latency", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        logic [7:0] seq [5];
        logic       r_rst, r_en, r_sl, r_rq;
        int         r_sin, r_lim;
        seq = '{8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'hFE};

        // Reset state and free-run sequence
        cycle(0, 0, 0, 0, 0, 0);
        chk("rst_raw", raw, 8'h0F);
        chk("rst_busy", busy, 0);
        chk("rst_valid", valid, 0);
        chk("rst_value", value, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(1, 1, 0, 0, 0, 0);
            chk("freerun_raw", raw, seq[i]);
        end

        // limit=0: accepted on first candidate
        cycle(0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 1, 0);
        chk("lim0_busy", busy, 1);
        cycle(1, 0, 0, 0, 0, 0);
        chk("lim0_valid", valid, 1);
        chk("lim0_value", value, 8'h0F);
        chk("lim0_raw", raw, 8'h1F);
        chk("lim0_busy_fall", busy, 0);

        // limit=10: four rejections then fallback; req while busy ignored
        cycle(0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 1, 10);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, (i < 3) ? 1'b1 : 1'b0, 3);
        chk("lim10_valid", valid, 1);
        chk("lim10_value", value, 5);
        chk("lim10_raw", raw, 8'hFF);

        // Reset mid-draw abandons it
        cycle(1, 0, 0, 0, 1, 10);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_value", value, 0);
        chk("midrst_raw", raw, 8'h0F);
        cycle(1, 0, 0, 0, 0, 0);
        chk("midrst_novalid", valid, 0);

        // limit=1: always zero, extra req while busy ignored
        cycle(1, 0, 0, 0, 1, 1);
        cycle(1, 0, 0, 0, 1, 0);
        chk("lim1_valid", valid, 1);
        chk("lim1_value", value, 0);
        cycle(1, 0, 0, 0, 0, 0);
        chk("lim1_single_valid", valid, 0);

        // Zero seed load
        cycle(1, 0, 1, 0, 0, 0);
`ifdef LFSR_LOCKUP_GUARD_EN
        chk("zero_seed_raw0", raw, 8'h0F);
        cycle(1, 1, 0, 0, 0, 0);
        chk("zero_seed_raw1", raw, 8'h1F);
`else
        chk("zero_seed_raw0", raw, 8'h00);
        cycle(1, 1, 0, 0, 0, 0);
        chk("zero_seed_raw1", raw, 8'h00);
`endif
        cycle(1, 0, 1, 'hA5, 0, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            r_rst = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
            r_en  = 1'($urandom_range(0, 1));
            r_rq  = ($urandom_range(0, 2) == 0);
            r_sl  = (m_busy == 0) && ($urandom_range(0, 9) == 0);
            r_sin = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 255));
            case ($urandom_range(0, 3))
                0:       r_lim = 0;
                1:       r_lim = 1;
                2:       r_lim = int'($urandom_range(2, 16));
                default: r_lim = int'($urandom_range(0, 255));
            endcase
            cycle(r_rst, r_en, r_sl, r_sin, r_rq, r_lim);
        end

        // Drain outstanding draws
        for (int i = 0; i < 2 * MAX_TRIES + 4 && m_busy > 0; i++) cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        chk("drain_pending", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
